// File: rtl/sequence_detector.sv
// -----------------------------------------------------------------------------
// sequence_detector
//   Moore serial bit-pattern detector for framing/marker detection on a serial
//   data path. One bit is consumed on every rising clk edge. `detected` is a
//   pure decode of the state register and goes high for the cycle after the
//   final pattern bit has been sampled.
//
//   Parameters:
//     PAT_LEN  - pattern length in bits (2..16)
//     PATTERN  - pattern to match; bit [PAT_LEN-1] is received first
//     OVERLAP  - 1: a suffix of a match may begin the next match
//                0: matching restarts from empty after a detection
//
//   Ports:
//     clk       in   clock, all updates on rising edge
//     reset     in   synchronous active-low reset (0 = reset)
//     inBit     in   serial data bit
//     detected  out  high while the FSM sits in the match state
//
//   State | meaning
//   ------+-----------------------------------------------------------
//   S0    | nothing matched
//   Sk    | first k pattern bits equal the k most recent input bits
//   S_MATCH (=S_PAT_LEN) | full pattern just received; detected = 1
// -----------------------------------------------------------------------------
module sequence_detector #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter bit                 OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic inBit,
  output logic detected
);

  localparam int ST_W = $clog2(PAT_LEN + 1);
  localparam int N_ST = 1 << ST_W;

  localparam logic [ST_W-1:0] S0      = '0;
  localparam logic [ST_W-1:0] S_MATCH = ST_W'(PAT_LEN);

  // Pattern bit in reception order: index 0 is the first bit received.
  function automatic int pat_bit(input int i);
    return PATTERN[PAT_LEN-1-i] ? 1 : 0;
  endfunction

  // KMP transition: longest prefix of the pattern that is a suffix of
  // (first k pattern bits followed by b). In non-overlap mode the match
  // state forgets its history and behaves like S0.
  function automatic int kmp_next(input int k, input int b);
    int  kk;
    int  hlen;
    int  res;
    int  hpos;
    int  hb;
    bit  ok;
    kk = k;
    if (k == PAT_LEN && !OVERLAP) kk = 0;
    hlen = kk + 1;
    res  = 0;
    for (int j = 1; j <= PAT_LEN; j++) begin
      if (j <= hlen) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          hpos = hlen - j + i;
          hb   = (hpos == kk) ? b : pat_bit(hpos);
          if (pat_bit(i) != hb) ok = 1'b0;
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Transition tables indexed by the current state, one per input value.
  // Encodings beyond S_MATCH are unreachable; they fall back to S0.
  logic [ST_W-1:0] nxt0 [N_ST];
  logic [ST_W-1:0] nxt1 [N_ST];

  for (genvar k = 0; k < N_ST; k++) begin : g_next
    if (k <= PAT_LEN) begin : g_live
      localparam logic [ST_W-1:0] NX0 = ST_W'(kmp_next(k, 0));
      localparam logic [ST_W-1:0] NX1 = ST_W'(kmp_next(k, 1));
      assign nxt0[k] = NX0;
      assign nxt1[k] = NX1;
    end else begin : g_unused
      assign nxt0[k] = S0;
      assign nxt1[k] = S0;
    end
  end

  logic [ST_W-1:0] state_q;
  logic [ST_W-1:0] state_d;

  always_comb begin
    state_d = inBit ? nxt1[state_q] : nxt0[state_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign detected = (state_q == S_MATCH);

endmodule

// File: tb/tb_sequence_detector.sv
module tb_sequence_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       inBit;
  logic [3:0] det;

  always #5 clk = ~clk;

  // 0: 1001 overlap, 1: 1001 non-overlap, 2: 111 overlap, 3: 111 non-overlap
  sequence_detector u_ovl (.clk(clk), .reset(reset), .inBit(inBit), .detected(det[0]));
  sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0))
    u_nov (.clk(clk), .reset(reset), .inBit(inBit), .detected(det[1]));
  sequence_detector #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1))
    u_111o (.clk(clk), .reset(reset), .inBit(inBit), .detected(det[2]));
  sequence_detector #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0))
    u_111n (.clk(clk), .reset(reset), .inBit(inBit), .detected(det[3]));

  int vectors     = 0;
  int miscompares = 0;
  int pulses0     = 0;

  // Reference model: raw bit history plus count of bits since the last
  // restart point (reset, or a detection in non-overlap mode).
  logic [15:0] hist [4];
  int          cnt  [4];
  logic [3:0]  exp_det;

  function automatic int cfg_len(input int i);
    return (i < 2) ? 4 : 3;
  endfunction
  function automatic logic [15:0] cfg_pat(input int i);
    return (i < 2) ? 16'h0009 : 16'h0007;
  endfunction
  function automatic bit cfg_ovl(input int i);
    return (i == 0) || (i == 2);
  endfunction

  task automatic check(input string tag);
    for (int i = 0; i < 4; i++) begin
      assert (det[i] === exp_det[i]) else begin
        miscompares++;
        $error("FAIL %s dut%0d observed=%b expected=%b", tag, i, det[i], exp_det[i]);
      end
    end
  endtask

  task automatic step(input logic b, input logic rst_n, input string tag);
    logic [15:0] mask;
    bit          match;
    inBit = b;
    reset = rst_n;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        cnt[i]     = 0;
        hist[i]    = '0;
        exp_det[i] = 1'b0;
      end else begin
        hist[i] = {hist[i][14:0], b};
        cnt[i]++;
        mask  = (16'(1) << cfg_len(i)) - 16'(1);
        match = (cnt[i] >= cfg_len(i)) && ((hist[i] & mask) == cfg_pat(i));
        exp_det[i] = match;
        if (match && !cfg_ovl(i)) cnt[i] = 0;
      end
    end
    vectors++;
    #1;
    check(tag);
    if (det[0] === 1'b1) pulses0++;
    // Output must not follow inBit combinationally.
    inBit = ~b;
    #1;
    check({tag, "_comb"});
  endtask

  task automatic run_bits(input logic [39:0] v, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, tag);
  endtask

  initial begin
    logic [39:0] v;
    reset = 1'b0;
    inBit = 1'b0;
    exp_det = '0;
    for (int i = 0; i < 4; i++) begin
      hist[i] = '0;
      cnt[i]  = 0;
    end
    @(negedge clk);

    // Test 1: reset, then 0010010010 -> two pulses on the overlap 1001 unit
    step(1'b0, 1'b0, "t1_reset");
    pulses0 = 0;
    v = 40'b0010010010;
    run_bits(v, 10, "t1");
    assert (pulses0 === 2) else begin
      miscompares++;
      $error("FAIL t1_pulse_count observed=%0d expected=2", pulses0);
    end

    // Test 2: 1001001, overlap vs non-overlap
    step(1'b0, 1'b0, "t2_reset");
    v = 40'b1001001;
    run_bits(v, 7, "t2");

    // Test 3: reset mid-pattern discards history
    step(1'b0, 1'b0, "t3_reset");
    v = 40'b100;
    run_bits(v, 3, "t3_pre");
    step(1'b1, 1'b0, "t3_midreset");
    step(1'b1, 1'b1, "t3_post");

    // Test 4: 11001 exercises the S1 self-loop
    step(1'b0, 1'b0, "t4_reset");
    v = 40'b11001;
    run_bits(v, 5, "t4");

    // Test 5: 20 zeros then 20 ones
    step(1'b0, 1'b0, "t5_reset");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "t5_zeros");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "t5_ones");

    // Test 6: five ones on the 111 units
    step(1'b0, 1'b0, "t6_reset");
    v = 40'b11111;
    run_bits(v, 5, "t6");

    // Random stream biased toward 1001 fragments, with occasional resets
    step(1'b0, 1'b0, "rnd_reset");
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(1'($urandom_range(0, 1)), 1'b0, "rnd_rst");
      end else if ($urandom_range(0, 3) == 0) begin
        v = 40'b1001;
        run_bits(v, 4, "rnd_pat");
      end else begin
        step(1'($urandom_range(0, 1)), 1'b1, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
